// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// ALU operations, datapath select values, FSM states and the control bundle.
package mcpu_pkg;

    localparam int ALUC_W = 4;
    localparam int OP_W   = 6;

    // Primary opcodes, instr[31:26]
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type function codes, instr[5:0]
    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR = 6'h26;
    localparam logic [OP_W-1:0] FN_NOR = 6'h27;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SLT = 4'b0110
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    // Encodings 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_e;

    // Everything the state decode produces; all-zero is the idle/reset value.
    typedef struct packed {
        logic    pc_write;
        logic    branch;
        logic    iord;
        logic    mem_write;
        logic    ir_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    reg_write;
        logic    alu_src_a;
        srcb_e   alu_src_b;
        pcsrc_e  pc_src;
        alu_op_e alu_control;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mcpu_ctrl_fsm_if.sv
// Controller <-> datapath control bundle. The controller is the master: it
// receives instruction fields and the zero flag and drives all selects/enables.
interface mcpu_ctrl_fsm_if;

    logic [mcpu_pkg::OP_W-1:0]   op;
    logic [mcpu_pkg::OP_W-1:0]   funct;
    logic                        zero;

    logic                        pc_en;
    logic                        iord;
    logic                        mem_write;
    logic                        ir_write;
    logic                        reg_dst;
    logic                        mem_to_reg;
    logic                        reg_write;
    logic                        alu_src_a;
    logic [1:0]                  alu_src_b;
    logic [1:0]                  pc_src;
    logic [mcpu_pkg::ALUC_W-1:0] alu_control;
    logic [3:0]                  state_dbg;

    modport master (
        input  op, funct, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control, state_dbg
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control, state_dbg
    );

endinterface

// File: rtl/mcpu_alu_dec.sv
// R-type funct -> ALU operation decoder; valid is low for unsupported funct.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  logic [OP_W-1:0] funct,
    output alu_op_e         alu_op,
    output logic            valid
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving the datapath selects and enables.
module mcpu_ctrl_fsm
    import mcpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mcpu_ctrl_fsm_if.master   dp
);

    state_e  state;
    state_e  state_nxt;
    ctrl_t   ctrl;
    ctrl_t   ctrl_out;
    alu_op_e rtype_op;
    logic    rtype_ok;

    mcpu_alu_dec u_alu_dec (
        .funct  (dp.funct),
        .alu_op (rtype_op),
        .valid  (rtype_ok)
    );

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        ctrl      = '0;
        case (state)
            FETCH: begin
                ctrl.ir_write    = 1'b1;
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.alu_control = ALU_ADD;
                ctrl.pc_src      = PCSRC_ALU;
                ctrl.pc_write    = 1'b1;
                state_nxt        = DECODE;
            end
            DECODE: begin
                // Speculative branch target PC + (imm << 2) lands in ALUOut.
                ctrl.alu_src_b   = SRCB_IMM_SH2;
                ctrl.alu_control = ALU_ADD;
                if (is_mem_op(dp.op)) begin
                    state_nxt = MEMADR;
                end else begin
                    case (dp.op)
                        OP_RTYPE: state_nxt = rtype_ok ? REXEC : FETCH;
                        OP_BEQ:   state_nxt = BRANCH;
                        OP_ADDI:  state_nxt = IEXEC;
                        OP_J:     state_nxt = JUMP;
                        default:  state_nxt = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
                state_nxt        = (dp.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                state_nxt       = FETCH;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_nxt      = FETCH;
            end
            REXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = rtype_op;
                state_nxt        = RWB;
            end
            RWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                state_nxt      = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_REG;
                ctrl.alu_control = ALU_SUB;
                ctrl.branch      = 1'b1;
                ctrl.pc_src      = PCSRC_ALUOUT;
                state_nxt        = FETCH;
            end
            IEXEC: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_IMM;
                ctrl.alu_control = ALU_ADD;
                state_nxt        = IWB;
            end
            IWB: begin
                ctrl.reg_write = 1'b1;
                state_nxt      = FETCH;
            end
            JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
                state_nxt     = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // The reset state is FETCH, which would otherwise assert pc_en/ir_write;
    // gating with rst_n keeps every enable low for as long as reset is held.
    assign ctrl_out = rst_n ? ctrl : '0;

    assign dp.pc_en       = ctrl_out.pc_write | (ctrl_out.branch & dp.zero);
    assign dp.iord        = ctrl_out.iord;
    assign dp.mem_write   = ctrl_out.mem_write;
    assign dp.ir_write    = ctrl_out.ir_write;
    assign dp.reg_dst     = ctrl_out.reg_dst;
    assign dp.mem_to_reg  = ctrl_out.mem_to_reg;
    assign dp.reg_write   = ctrl_out.reg_write;
    assign dp.alu_src_a   = ctrl_out.alu_src_a;
    assign dp.alu_src_b   = ctrl_out.alu_src_b;
    assign dp.pc_src      = ctrl_out.pc_src;
    assign dp.alu_control = ctrl_out.alu_control;
    assign dp.state_dbg   = state;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Scoreboard bench for mcpu_ctrl_fsm: the driver queues per-cycle expected
// control words, a negedge monitor pops and compares each cycle.
module tb_mcpu_ctrl_fsm;
    import mcpu_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic [3:0] aluc;
    } obs_t;

    typedef struct {
        obs_t  v;
        obs_t  c;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    obs_t obs;

    mcpu_ctrl_fsm_if dp ();

    mcpu_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp.master)
    );

    always #5 clk = ~clk;

    assign obs = {dp.state_dbg, dp.pc_en, dp.iord, dp.mem_write, dp.ir_write,
                  dp.reg_dst, dp.mem_to_reg, dp.reg_write, dp.alu_src_a,
                  dp.alu_src_b, dp.pc_src, dp.alu_control};

    task automatic check(input string name, input obs_t act, input obs_t exp, input obs_t care);
        checks++;
        if ((act & care) !== (exp & care)) begin
            failures++;
            $display("FAIL %s: got %h required %h (care %h)", name, act, exp, care);
        end
    endtask

    // Expected control word for one state, written out from the state table.
    function automatic exp_t mk(input state_e s, input logic [3:0] aluc, input logic z, input string tag);
        exp_t e;
        e.v = '0;
        e.c = '0;
        e.name = {tag, ":", s.name()};
        e.v.st = s;
        e.c.st = '1;
        e.c.pc_en = 1'b1;
        e.c.mem_write = 1'b1;
        e.c.ir_write = 1'b1;
        e.c.reg_write = 1'b1;
        case (s)
            FETCH: begin
                e.v.ir_write = 1'b1; e.v.src_b = 2'b01; e.v.pc_en = 1'b1;
                e.c.iord = 1'b1; e.c.src_a = 1'b1; e.c.src_b = '1; e.c.aluc = '1; e.c.pc_src = '1;
            end
            DECODE: begin
                e.v.src_b = 2'b11;
                e.c.src_a = 1'b1; e.c.src_b = '1; e.c.aluc = '1;
            end
            MEMADR, IEXEC: begin
                e.v.src_a = 1'b1; e.v.src_b = 2'b10;
                e.c.src_a = 1'b1; e.c.src_b = '1; e.c.aluc = '1;
            end
            MEMRD: begin
                e.v.iord = 1'b1; e.c.iord = 1'b1;
            end
            MEMWB: begin
                e.v.mem_to_reg = 1'b1; e.v.reg_write = 1'b1;
                e.c.reg_dst = 1'b1; e.c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                e.v.iord = 1'b1; e.v.mem_write = 1'b1; e.c.iord = 1'b1;
            end
            REXEC: begin
                e.v.src_a = 1'b1; e.v.aluc = aluc;
                e.c.src_a = 1'b1; e.c.src_b = '1; e.c.aluc = '1;
            end
            RWB: begin
                e.v.reg_dst = 1'b1; e.v.reg_write = 1'b1;
                e.c.reg_dst = 1'b1; e.c.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                e.v.src_a = 1'b1; e.v.aluc = 4'b0001; e.v.pc_src = 2'b01; e.v.pc_en = z;
                e.c.src_a = 1'b1; e.c.src_b = '1; e.c.aluc = '1; e.c.pc_src = '1;
            end
            IWB: begin
                e.v.reg_write = 1'b1;
                e.c.reg_dst = 1'b1; e.c.mem_to_reg = 1'b1;
            end
            JUMP: begin
                e.v.pc_src = 2'b10; e.v.pc_en = 1'b1; e.c.pc_src = '1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: the DUT presents one control word per cycle once out of reset.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                check("unexpected_cycle", obs, '1, '1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, obs, e.v, e.c);
            end
        end
    end

    task automatic set_inputs(input logic [5:0] op, input logic [5:0] fn, input logic z);
        dp.op = op;
        dp.funct = fn;
        dp.zero = z;
    endtask

    task automatic push(input state_e s, input logic [3:0] aluc, input logic z, input string tag);
        sb.push_back(mk(s, aluc, z, tag));
    endtask

    // Called right after a posedge that lands in FETCH; leaves time just after
    // the posedge that starts the next instruction.
    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        obs_t z;
        z = '0;
        z.st = FETCH;
        check(name, obs, z, '1);
    endtask

    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [3:0] ac_tab [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

    initial begin
        set_inputs(6'b111111, 6'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");

        // lw: five states, release reset while inputs are already set
        set_inputs(OP_LW, 6'h00, 1'b0);
        push(FETCH, 0, 0, "lw"); push(DECODE, 0, 0, "lw"); push(MEMADR, 0, 0, "lw");
        push(MEMRD, 0, 0, "lw"); push(MEMWB, 0, 0, "lw");
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_cycles(5);

        // R-type sweep over every supported funct
        for (int i = 0; i < 7; i++) begin
            set_inputs(OP_RTYPE, fn_tab[i], 1'b0);
            push(FETCH, 0, 0, "rtype"); push(DECODE, 0, 0, "rtype");
            push(REXEC, ac_tab[i], 0, "rtype"); push(RWB, 0, 0, "rtype");
            run_cycles(4);
        end

        // Unsupported funct aborts after DECODE
        set_inputs(OP_RTYPE, 6'h3F, 1'b0);
        push(FETCH, 0, 0, "bad_funct"); push(DECODE, 0, 0, "bad_funct");
        run_cycles(2);

        // beq taken then not taken
        set_inputs(OP_BEQ, 6'h00, 1'b1);
        push(FETCH, 0, 1, "beq_t"); push(DECODE, 0, 1, "beq_t"); push(BRANCH, 0, 1, "beq_t");
        run_cycles(3);
        set_inputs(OP_BEQ, 6'h00, 1'b0);
        push(FETCH, 0, 0, "beq_nt"); push(DECODE, 0, 0, "beq_nt"); push(BRANCH, 0, 0, "beq_nt");
        run_cycles(3);

        // sw then j
        set_inputs(OP_SW, 6'h00, 1'b0);
        push(FETCH, 0, 0, "sw"); push(DECODE, 0, 0, "sw"); push(MEMADR, 0, 0, "sw");
        push(MEMWR, 0, 0, "sw");
        run_cycles(4);
        set_inputs(OP_J, 6'h00, 1'b0);
        push(FETCH, 0, 0, "j"); push(DECODE, 0, 0, "j"); push(JUMP, 0, 0, "j");
        run_cycles(3);

        // addi
        set_inputs(OP_ADDI, 6'h00, 1'b0);
        push(FETCH, 0, 0, "addi"); push(DECODE, 0, 0, "addi"); push(IEXEC, 0, 0, "addi");
        push(IWB, 0, 0, "addi");
        run_cycles(4);

        // illegal opcode
        set_inputs(6'b111111, 6'h00, 1'b0);
        push(FETCH, 0, 0, "illegal"); push(DECODE, 0, 0, "illegal");
        run_cycles(2);

        // lw interrupted by async reset while in MEMWB
        set_inputs(OP_LW, 6'h00, 1'b0);
        push(FETCH, 0, 0, "lw_rst"); push(DECODE, 0, 0, "lw_rst"); push(MEMADR, 0, 0, "lw_rst");
        push(MEMRD, 0, 0, "lw_rst"); push(MEMWB, 0, 0, "lw_rst");
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_memwb");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");

        // restart after release with addi
        set_inputs(OP_ADDI, 6'h00, 1'b0);
        push(FETCH, 0, 0, "post_rst"); push(DECODE, 0, 0, "post_rst");
        push(IEXEC, 0, 0, "post_rst"); push(IWB, 0, 0, "post_rst");
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_cycles(4);
        mon_en = 1'b0;

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
